dmem_responder: RTL and testbench

//   Data-memory target that serves the core's load/store requests over a

---
 rtl/rv_mem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I access codes,
// responder FSM states and request legality helpers.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    ACC_B  = 3'b000,
    ACC_H  = 3'b001,
    ACC_W  = 3'b010,
    ACC_BU = 3'b100,
    ACC_HU = 3'b101
  } access_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] access, input logic [1:0] byte_off);
    case (access)
      ACC_H, ACC_HU: return byte_off[0];
      ACC_W:         return byte_off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic is_legal_access(input logic [2:0] access, input logic is_store);
    case (access)
      ACC_B, ACC_H, ACC_W: return 1'b1;
      ACC_BU, ACC_HU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core and a little-endian 32-bit word:
// store byte mask and replicated store data, and extended load data.
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  access,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = rd_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[byte_off];
  assign sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  // Store data is replicated across all lanes; the mask picks the live ones.
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = wdata;
    load_data  = '0;
    case (access)
      ACC_B: begin
        wmask      = 4'b0001 << byte_off;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = {{24{sel_byte[7]}}, sel_byte};
      end
      ACC_BU: load_data = {24'b0, sel_byte};
      ACC_H: begin
        wmask      = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = {{16{sel_half[15]}}, sel_half};
      end
      ACC_HU: load_data = {16'b0, sel_half};
      ACC_W: begin
        wmask     = 4'b1111;
        load_data = rd_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's MEM stage: latches a load/store request,
// waits WAIT_CYCLES, then answers with a one-cycle ack (err on rejection).
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  access,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [31:0]    addr_reg;
  logic [31:0]    wdata_reg;
  logic [2:0]     access_reg;
  logic           load_reg;
  logic           store_reg;
  logic           ack_reg;
  logic           err_reg;
  logic [31:0]    rd_word_reg;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           req;
  logic           in_idle;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_wdata;
  logic [2:0]     sel_access;
  logic           sel_load;
  logic           sel_store;
  logic [AW-1:0]  sel_idx;
  logic           out_of_range;
  logic           req_err;
  logic           enter_resp;
  logic           mem_we;
  logic [3:0]     wmask;
  logic [31:0]    wdata_lane;
  logic [31:0]    load_data;

  assign req     = load | store;
  assign in_idle = (state_reg == IDLE);

  // In IDLE the live request is used so a zero-wait access can commit on its
  // acceptance edge; afterwards only the latched copy matters.
  assign sel_addr   = in_idle ? addr   : addr_reg;
  assign sel_wdata  = in_idle ? wdata  : wdata_reg;
  assign sel_access = in_idle ? access : access_reg;
  assign sel_load   = in_idle ? load   : load_reg;
  assign sel_store  = in_idle ? store  : store_reg;
  assign sel_idx    = sel_addr[2 +: AW];

  assign out_of_range = {2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign req_err      = (sel_load & sel_store)
                      | !is_legal_access(sel_access, sel_store)
                      | is_misaligned(sel_access, sel_addr[1:0])
                      | out_of_range;

  assign enter_resp = in_idle ? (req && (WAIT_CYCLES == 0))
                              : ((state_reg == WAIT) && (cnt_reg == CNT_LAST));
  assign mem_we     = enter_resp & ~rst & sel_store & ~req_err;

  dmem_lane_align u_lane_align (
    .access     (sel_access),
    .byte_off   (sel_addr[1:0]),
    .rd_word    (rd_word_reg),
    .wdata      (sel_wdata),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      access_reg <= '0;
      load_reg   <= 1'b0;
      store_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg   <= addr;
            wdata_reg  <= wdata;
            access_reg <= access;
            load_reg   <= load;
            store_reg  <= store;
            cnt_reg    <= '0;
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESP;
              ack_reg   <= 1'b1;
              err_reg   <= req_err;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= RESP;
            ack_reg   <= 1'b1;
            err_reg   <= req_err;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Storage: per-byte write enables and a registered read on the same edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && wmask[b]) begin
        mem[sel_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
    rd_word_reg <= mem[sel_idx];
  end

  assign ack   = ack_reg;
  assign err   = err_reg;
  assign rdata = (ack_reg && !err_reg && load_reg) ? load_data : '0;
  assign stall = req & ~ack_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states)
// checked against a byte-level reference memory model.
module tb_dmem_responder;
  import rv_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic        load_s  [2];
  logic        store_s [2];
  logic [2:0]  acc_s   [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic        stall_s [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .load(load_s[0]), .store(store_s[0]),
    .access(acc_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .rdata(rdata_s[0]), .ack(ack_s[0]), .err(err_s[0]), .stall(stall_s[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .load(load_s[1]), .store(store_s[1]),
    .access(acc_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .rdata(rdata_s[1]), .ack(ack_s[1]), .err(err_s[1]), .stall(stall_s[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ack_cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [7:0]  mdl [longint];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waits(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, req);
    end
  endtask

  // Reference: byte-addressed memory, access rules applied directly.
  function automatic void model(input int d, input bit ld, input bit st, input logic [2:0] acc,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rv, output logic e);
    int unsigned size;
    longint      base;
    logic [31:0] v;
    size = (acc[1:0] == 2'd0) ? 1 : (acc[1:0] == 2'd1) ? 2 : 4;
    e = (ld && st) || acc == 3'd3 || acc == 3'd6 || acc == 3'd7 || (st && acc[2])
        || (a % size != 0) || (a / 4 >= DEPTH);
    rv = '0;
    if (e) return;
    base = longint'(d) * 64'h1_0000_0000;
    if (st) begin
      for (int i = 0; i < int'(size); i++) mdl[base + longint'(a) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(size); i++) v = v | (32'(mdl[base + longint'(a) + i]) << (8*i));
      if (acc == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (acc == 3'd1) v = {{16{v[15]}}, v[15:0]};
      rv = v;
    end
  endfunction

  task automatic req(input int d, input bit ld, input bit st, input logic [2:0] acc,
                     input logic [31:0] a, input logic [31:0] wd, input bit scramble);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    model(d, ld, st, acc, a, wd, e.rdata, e.err);
    e.ack_cyc = cyc + waits(d) + 1;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    load_s[d] = ld; store_s[d] = st; acc_s[d] = acc; addr_s[d] = a; wdata_s[d] = wd;
    got = 0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      check("stall", d, 32'(stall_s[d]), 32'(!ack_s[d]));
      if (ack_s[d]) got = 1;
      else if (scramble && n == 0) begin
        @(posedge clk); #1;
        addr_s[d]  = 32'h0000_0044;
        wdata_s[d] = $urandom;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d addr=%h: got no ack expected ack", d, a);
    end
  endtask

  task automatic drop(input int d);
    @(posedge clk); #1;
    load_s[d]  = 1'b0;
    store_s[d] = 1'b0;
  endtask

  task automatic mon(input int d);
    exp_t e;
    bit   empty;
    if (rst_s[d]) return;
    if (ack_s[d]) begin
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack dut%0d cyc=%0d: got ack expected none", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        $display("dut%0d ack cyc=%0d rdata=%h err=%b (exp %h/%b @%0d)",
                 d, cyc, rdata_s[d], err_s[d], e.rdata, e.err, e.ack_cyc);
        check("rdata", d, rdata_s[d], e.rdata);
        check("err", d, 32'(err_s[d]), 32'(e.err));
        check("ack_cycle", d, 32'(cyc), 32'(e.ack_cyc));
      end
    end else begin
      check("idle_rdata", d, rdata_s[d], 32'h0);
      check("idle_err", d, 32'(err_s[d]), 32'h0);
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; load_s[d] = 1'b0; store_s[d] = 1'b0;
      acc_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", d, 32'(ack_s[d]), 32'h0);
      check("reset_err", d, 32'(err_s[d]), 32'h0);
      check("reset_rdata", d, rdata_s[d], 32'h0);
      check("reset_stall", d, 32'(stall_s[d]), 32'h0);
    end

    // Known contents for words 0..31 and the last word of both instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) req(d, 0, 1, ACC_W, 32'(w * 4), 32'h0101_0101 * w, 0);
      req(d, 0, 1, ACC_W, 32'((DEPTH - 1) * 4), 32'hA5C3_0FF0, 0);
      req(d, 1, 0, ACC_W, 32'((DEPTH - 1) * 4), 32'h0, 0);
      drop(d);
    end

    req(0, 0, 1, ACC_W, 32'h10, 32'hDEAD_BEEF, 0); drop(0);
    req(0, 1, 0, ACC_W, 32'h10, 32'h0, 0);          drop(0);

    req(0, 0, 1, ACC_W,  32'h10, 32'h0, 0);  drop(0);
    req(0, 0, 1, ACC_B,  32'h11, 32'h80, 0); drop(0);
    req(0, 1, 0, ACC_B,  32'h11, 32'h0, 0);  drop(0);
    req(0, 1, 0, ACC_BU, 32'h11, 32'h0, 0);  drop(0);
    req(0, 1, 0, ACC_W,  32'h10, 32'h0, 0);  drop(0);

    req(0, 1, 0, ACC_H, 32'h13, 32'h0, 0);                 drop(0);
    req(0, 0, 1, ACC_W, 32'h12, 32'hFFFF_FFFF, 0);         drop(0);
    req(0, 1, 0, ACC_W, 32'(DEPTH * 4), 32'h0, 0);         drop(0);
    req(0, 1, 0, ACC_W, 32'h10, 32'h0, 0);                 drop(0);

    // Zero-wait instance: back-to-back loads with no idle gap.
    for (int i = 0; i < 6; i++) req(1, 1, 0, ACC_W, 32'(i * 4), 32'h0, 0);
    drop(1);

    // Reset lands during the wait of a store: no ack, no write.
    req(0, 0, 1, ACC_W, 32'h20, 32'hAAAA_5555, 0); drop(0);
    @(posedge clk); #1;
    store_s[0] = 1'b1; acc_s[0] = ACC_W; addr_s[0] = 32'h20; wdata_s[0] = 32'h1234_5678;
    @(posedge clk); #1;
    rst_s[0] = 1'b1; store_s[0] = 1'b0;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    req(0, 1, 0, ACC_W, 32'h20, 32'h0, 0); drop(0);

    // Inputs disturbed while waiting must not affect the store.
    req(0, 0, 1, ACC_W, 32'h30, 32'h5A5A_1234, 1); drop(0);
    req(0, 1, 0, ACC_W, 32'h30, 32'h0, 0);         drop(0);
    req(0, 1, 0, ACC_W, 32'h44, 32'h0, 0);         drop(0);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        int          r;
        logic [2:0]  acc;
        logic [31:0] a;
        r   = $urandom_range(0, 9);
        acc = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
        else                            a = 32'h40 + 32'($urandom_range(0, 63));
        if (r == 0)      req(d, 1, 1, acc, a, $urandom, 0);
        else if (r < 5)  req(d, 0, 1, acc, a, $urandom, 0);
        else             req(d, 1, 0, acc, a, 32'h0, 0);
        if ($urandom_range(0, 1) == 1) drop(d);
      end
      drop(d);
    end

    repeat (6) @(posedge clk);
    check("pending_dut0", 0, 32'(q0.size()), 32'h0);
    check("pending_dut1", 1, 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
